// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: valid/ready register chain (bypass, simple or skid stages) with occupancy and flush.
// Define PIPE_REG_CHAIN_STATS_EN to add saturating beat_count/stall_count outputs.
module pipe_reg_chain #(
    parameter int  DATA_WIDTH = 64,
    parameter int  REG_TYPE   = 2,
    parameter int  REG_LENGTH = 1,
    localparam int OCC_WIDTH  = $clog2(2*REG_LENGTH+2)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [OCC_WIDTH-1:0]  occupancy
`ifdef PIPE_REG_CHAIN_STATS_EN
    ,
    output logic [31:0]           beat_count,
    output logic [31:0]           stall_count
`endif
);

`ifdef PIPE_REG_CHAIN_STATS_EN
    logic [31:0] r_beat_cnt, r_stall_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (m_valid && m_ready && r_beat_cnt != '1) r_beat_cnt <= r_beat_cnt + 32'd1;
            if (m_valid && !m_ready && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end
    assign beat_count  = r_beat_cnt;
    assign stall_count = r_stall_cnt;
`endif

    generate
        if (REG_TYPE == 0 || REG_LENGTH == 0) begin : g_bypass
            assign m_data    = s_data;
            assign m_valid   = s_valid;
            assign s_ready   = m_ready;
            assign occupancy = '0;
        end else begin : g_chain
            logic [1:0]            r_sync;
            logic [OCC_WIDTH-1:0]  r_occ;
            logic [REG_LENGTH-1:0] w_q, w_rdy;
            logic [DATA_WIDTH-1:0] w_qd [REG_LENGTH];
            logic                  w_s_xfer, w_m_xfer, w_m_rdy;
            // Reset release is synchronised so s_ready rises on the second edge after rst_n.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_sync <= 2'b00;
                else        r_sync <= {r_sync[0], 1'b1};
            end
            assign s_ready   = w_rdy[0] & r_sync[1] & ~flush;
            assign w_s_xfer  = s_valid & s_ready;
            assign w_m_rdy   = m_ready & ~flush;
            assign m_valid   = w_q[REG_LENGTH-1] & ~flush;
            assign m_data    = w_qd[REG_LENGTH-1];
            assign w_m_xfer  = m_valid & m_ready;
            assign occupancy = r_occ;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                       r_occ <= '0;
                else if (flush)                   r_occ <= '0;
                else if (w_s_xfer && !w_m_xfer)   r_occ <= r_occ + 1'b1;
                else if (!w_s_xfer && w_m_xfer)   r_occ <= r_occ - 1'b1;
            end
            for (genvar i = 0; i < REG_LENGTH; i++) begin : g_stage
                logic                  w_iv, w_or;
                logic [DATA_WIDTH-1:0] w_id;
                if (i == 0) begin : g_head
                    assign w_iv = w_s_xfer;
                    assign w_id = s_data;
                end else begin : g_link
                    assign w_iv = w_q[i-1];
                    assign w_id = w_qd[i-1];
                end
                if (i == REG_LENGTH-1) begin : g_tail
                    assign w_or = w_m_rdy;
                end else begin : g_mid
                    assign w_or = w_rdy[i+1];
                end
                if (REG_TYPE == 1) begin : g_simple
                    logic                  r_v;
                    logic [DATA_WIDTH-1:0] r_d;
                    // Closed form of the ready chain: any empty stage downstream frees this one.
                    assign w_rdy[i] = w_m_rdy | (~&w_q[REG_LENGTH-1:i]);
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n)      r_v <= 1'b0;
                        else if (flush)  r_v <= 1'b0;
                        else if (w_rdy[i]) begin
                            r_v <= w_iv;
                            if (w_iv) r_d <= w_id;
                        end
                    end
                    assign w_q[i]  = r_v;
                    assign w_qd[i] = r_d;
                end else begin : g_skid
                    logic                  r_v, r_sv;
                    logic [DATA_WIDTH-1:0] r_d, r_sd;
                    logic                  w_in;
                    assign w_rdy[i] = ~r_sv;
                    assign w_in     = w_iv & ~r_sv;
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) begin
                            r_v  <= 1'b0;
                            r_sv <= 1'b0;
                        end else if (flush) begin
                            r_v  <= 1'b0;
                            r_sv <= 1'b0;
                        end else if (!r_v || w_or) begin
                            if (r_sv) begin
                                r_v  <= 1'b1;
                                r_d  <= r_sd;
                                r_sv <= 1'b0;
                            end else begin
                                r_v <= w_in;
                                if (w_in) r_d <= w_id;
                            end
                        end else if (w_in) begin
                            r_sv <= 1'b1;
                            r_sd <= w_id;
                        end
                    end
                    assign w_q[i]  = r_v;
                    assign w_qd[i] = r_d;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: three chain configurations on shared stimulus, checked against a queue model.
module tb_pipe_reg_chain;
    localparam int DW = 16;

    logic          clk = 1'b0, rst_n = 1'b0, flush = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic [2:0]    sr, mv;
    logic [DW-1:0] md [3];
    logic [2:0]    occ_a, occ_b;
    logic [1:0]    occ_c;
`ifdef PIPE_REG_CHAIN_STATS_EN
    logic [31:0]   bc [3];
    logic [31:0]   sc [3];
`endif

    logic [DW-1:0] q [3][$];
    int            cap [3] = '{6, 4, 1};
    int            n_vec = 0, n_err = 0, exp_beat = 0, exp_stall = 0;
    bit            armed = 1'b0;

    always #5 clk = ~clk;

    pipe_reg_chain #(.DATA_WIDTH(DW), .REG_TYPE(2), .REG_LENGTH(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .s_data(s_data), .s_valid(s_valid), .s_ready(sr[0]),
        .m_data(md[0]), .m_valid(mv[0]), .m_ready(m_ready), .occupancy(occ_a)
`ifdef PIPE_REG_CHAIN_STATS_EN
        , .beat_count(bc[0]), .stall_count(sc[0])
`endif
    );
    pipe_reg_chain #(.DATA_WIDTH(DW), .REG_TYPE(2), .REG_LENGTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .s_data(s_data), .s_valid(s_valid), .s_ready(sr[1]),
        .m_data(md[1]), .m_valid(mv[1]), .m_ready(m_ready), .occupancy(occ_b)
`ifdef PIPE_REG_CHAIN_STATS_EN
        , .beat_count(bc[1]), .stall_count(sc[1])
`endif
    );
    pipe_reg_chain #(.DATA_WIDTH(DW), .REG_TYPE(1), .REG_LENGTH(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush(flush), .s_data(s_data), .s_valid(s_valid), .s_ready(sr[2]),
        .m_data(md[2]), .m_valid(mv[2]), .m_ready(m_ready), .occupancy(occ_c)
`ifdef PIPE_REG_CHAIN_STATS_EN
        , .beat_count(bc[2]), .stall_count(sc[2])
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int occ_of(input int k);
        return k == 0 ? int'(occ_a) : k == 1 ? int'(occ_b) : int'(occ_c);
    endfunction

    // One cycle: drive at negedge, check settled outputs, then advance the model past the next edge.
    task automatic step(input logic sv, input logic [DW-1:0] sd, input logic mr, input logic fl);
        @(negedge clk);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        flush   = fl;
        #1;
        for (int k = 0; k < 3; k++) begin
            int n;
            n = q[k].size();
            chk($sformatf("occ%0d", k), 64'(occ_of(k)), 64'(n));
            chk($sformatf("spurious%0d", k), 64'(mv[k] && n == 0), 0);
            if (mv[k] && n > 0) chk($sformatf("data%0d", k), 64'(md[k]), 64'(q[k][0]));
            if (fl) begin
                chk($sformatf("flush_sready%0d", k), 64'(sr[k]), 0);
                chk($sformatf("flush_mvalid%0d", k), 64'(mv[k]), 0);
            end else if (armed) begin
                if (k == 2)            chk("t1_ready", 64'(sr[k]), 64'(mr | (n == 0)));
                else if (n == 0)       chk($sformatf("empty_ready%0d", k), 64'(sr[k]), 1);
                else if (n == cap[k])  chk($sformatf("full_ready%0d", k), 64'(sr[k]), 0);
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (fl) q[k].delete();
            else begin
                if (mv[k] && mr) void'(q[k].pop_front());
                if (sr[k] && sv) q[k].push_back(sd);
            end
        end
        if (mv[0] && mr)  exp_beat++;
        if (mv[0] && !mr) exp_stall++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        armed = 1'b0;
        {flush, s_valid, m_ready} = 3'b000;
        for (int k = 0; k < 3; k++) q[k].delete();
        exp_beat  = 0;
        exp_stall = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) chk($sformatf("sync_edge1_%0d", k), 64'(sr[k]), 0);
        step(1'b0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) chk($sformatf("sync_edge2_%0d", k), 64'(sr[k]), 1);
        armed = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b, got, first, last;
        for (int k = 0; k < 3; k++) chk($sformatf("rst_mvalid%0d", k), 64'(mv[k]), 0);
        chk("rst_occ_a", 64'(occ_a), 0);
        do_reset();

        step(1'b1, 16'h00A5, 1'b1, 1'b0);
        chk("lat_accept", 64'(sr[0]), 1);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("lat_mvalid", 64'(mv[0]), 64'(i == 3));
            chk("lat_occ", 64'(occ_a), 64'(i <= 3));
            if (i == 3) chk("lat_data", 64'(md[0]), 64'h00A5);
        end

        b = 1;
        for (int i = 0; i < 8; i++) begin
            step(b <= 10, DW'(b), 1'b0, 1'b0);
            if (sr[1] && b <= 10) b++;
        end
        chk("fill_count", 64'(b - 1), 4);
        chk("fill_sready", 64'(sr[1]), 0);
        chk("fill_occ", 64'(occ_b), 4);
        chk("t1_full_blocked", 64'(sr[2]), 0);
        got = 1;
        first = -1;
        last = -1;
        for (int i = 0; i < 40 && got <= 10; i++) begin
            step(b <= 10, DW'(b), 1'b1, 1'b0);
            if (i == 0) begin
                chk("t1_same_cycle_ready", 64'(sr[2]), 1);
                chk("t1_same_cycle_out", 64'(mv[2]), 1);
            end
            if (sr[1] && b <= 10) b++;
            if (mv[1]) begin
                chk("drain_order", 64'(md[1]), 64'(got));
                got++;
                if (first < 0) first = i;
                last = i;
            end
        end
        chk("drain_all", 64'(got), 11);
        chk("drain_gapless", 64'(last - first), 9);

        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 10 && q[0].size() < 3; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        step(1'b1, 16'hDEAD, 1'b1, 1'b1);
        chk("flush_occ_pre", 64'(occ_a), 3);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("flush_occ_post", 64'(occ_a), 0);
        chk("flush_ready_back", 64'(sr[0]), 1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("flush_no_old", 64'(mv[0]), 0);
        end

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 7, DW'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);

        for (int i = 0; i < 6; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        chk("burst_mvalid", 64'(mv[0]), 1);
        #3;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("async_mvalid%0d", k), 64'(mv[k]), 0);
            chk($sformatf("async_sready%0d", k), 64'(sr[k]), 0);
            chk($sformatf("async_occ%0d", k), 64'(occ_of(k)), 0);
        end
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("post_rst_quiet", 64'(mv), 0);
        end

`ifdef PIPE_REG_CHAIN_STATS_EN
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b0, '0, (i % 2) == 1, 1'b0);
        chk("beat_count", 64'(bc[0]), 64'(exp_beat));
        chk("stall_count", 64'(sc[0]), 64'(exp_stall));
        @(negedge clk);
        force dut_a.r_beat_cnt  = 32'hFFFF_FFFF;
        force dut_a.r_stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut_a.r_beat_cnt;
        release dut_a.r_stall_cnt;
        for (int i = 0; i < 12; i++) step(1'b1, DW'(i), (i % 3) == 0, 1'b0);
        chk("beat_saturate", 64'(bc[0]), 64'hFFFF_FFFF);
        chk("stall_saturate", 64'(sc[0]), 64'hFFFF_FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_reg_chain.md
PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: payload width in bits, 1..1024.
REQ-002 SHALL have parameter REG_TYPE, default 2: stage type, where 0 = bypass wires, 1 = simple register with combinational ready, 2 = skid buffer with registered ready.
REQ-003 SHALL have parameter REG_LENGTH, default 1: number of cascaded stages, 0..8; 0 forces bypass.
REQ-004 SHALL have derived localparam OCC_WIDTH = $clog2(2*REG_LENGTH+2): occupancy width.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port flush, input, 1 bit: synchronous discard of all in-flight beats.
REQ-008 SHALL have port s_data, input, DATA_WIDTH bits: upstream payload.
REQ-009 SHALL have port s_valid, input, 1 bit: upstream valid.
REQ-010 SHALL have port s_ready, output, 1 bit: upstream ready.
REQ-011 SHALL have port m_data, output, DATA_WIDTH bits: downstream payload.
REQ-012 SHALL have port m_valid, output, 1 bit: downstream valid.
REQ-013 SHALL have port m_ready, input, 1 bit: downstream ready.
REQ-014 SHALL have port occupancy, output, OCC_WIDTH bits: count of beats held in the chain.

Function
REQ-015 SHALL transfer a beat on any interface only in a cycle where valid and ready are both high; order SHALL be strictly FIFO with no loss and no duplication.
REQ-016 REG_TYPE 0 or REG_LENGTH 0 SHALL connect s to m combinationally with zero latency; occupancy SHALL be constant 0; flush SHALL have no effect.
REQ-017 REG_TYPE 1 SHALL give each stage one entry and 1-cycle latency; stage ready = downstream ready OR stage empty.
REQ-018 REG_TYPE 2 SHALL give each stage a main and a skid entry, 1-cycle latency, and a registered s_ready; the stage SHALL deassert ready only when the skid entry is full.
REQ-019 Total latency SHALL be REG_LENGTH cycles from s-transfer to m_valid when the chain is empty and m_ready is held high.
REQ-020 Full-rate throughput SHALL be sustained, i.e. one beat per cycle, while m_ready stays high.
REQ-021 occupancy SHALL be registered; it SHALL increment on an s-transfer alone, decrement on an m-transfer alone, and hold when both or neither occur.
REQ-022 occupancy maximum SHALL be REG_LENGTH (type 1) or 2*REG_LENGTH (type 2); s_ready SHALL be 0 whenever every entry is full.
REQ-023 m_data SHALL hold stable while m_valid=1 and m_ready=0.
REQ-024 When flush=1, s_ready and m_valid SHALL be forced 0 that cycle, so no transfer occurs.
REQ-025 After a flush, all entries SHALL be empty at the next edge, occupancy SHALL be 0, and s_ready=1 SHALL be restored the cycle after.
REQ-026 Flush SHALL take priority over any simultaneous s_valid or m_ready.

Reset
REQ-027 Asserting rst_n low SHALL, immediately and asynchronously, clear all valid bits and occupancy, drive m_valid=0 and s_ready=0, and leave m_data contents don't-care.
REQ-028 Reset deassertion SHALL be synchronised internally; s_ready SHALL go 1 on the second rising edge after rst_n rises.
REQ-029 Reset asserted mid-transfer SHALL discard all held beats; no beat SHALL appear on m after release.

Configuration
REQ-030 Macro PIPE_REG_CHAIN_STATS_EN, when defined, SHALL add output ports beat_count[31:0] and stall_count[31:0].
REQ-031 With the macro defined, beat_count SHALL increment on every m-transfer, and stall_count SHALL increment on every cycle with m_valid=1 and m_ready=0.
REQ-032 Both counters SHALL saturate at 32'hFFFFFFFF, clear only on reset, and be unaffected by flush.
REQ-033 Without the macro, these ports and counters SHALL be absent, and behaviour SHALL otherwise be identical.

Verification
REQ-034 Latency: REG_TYPE=2, REG_LENGTH=3, m_ready=1, single beat 0xA5 -> m_valid with m_data=0xA5 exactly 3 cycles after the s-transfer; occupancy steps 1,1,1 then 0.
REQ-035 Backpressure fill: REG_TYPE=2, REG_LENGTH=2, m_ready=0, s_valid=1 with beats 1..10 -> exactly 4 accepted, s_ready=0, occupancy=4; then m_ready=1 -> beats 1..10 emitted in order with no gaps after the first.
REQ-036 Type-1 ready path: REG_TYPE=1, REG_LENGTH=1, full stage, m_ready rising -> s_ready=1 in the same cycle and one beat in and one beat out that cycle.
REQ-037 Flush: occupancy=3 and flush pulsed together with s_valid=1 -> nothing accepted, m_valid=0 that cycle, occupancy=0 next cycle, no old beats emitted afterwards.
REQ-038 Async reset: rst_n low mid-burst, between clock edges -> m_valid=0 with no clock edge; s_ready=1 on the 2nd edge after release.
REQ-039 Stats: with PIPE_REG_CHAIN_STATS_EN, 5 transfers and 7 stall cycles -> beat_count=5 and stall_count=7; counters preloaded to the maximum by force -> they stay at 32'hFFFFFFFF.
